vec_step_ctrl: RTL and testbench

//  Stimulus sequencer. Holds a small table of input vectors, then applies them to a DUT's inputs in order.

---
 rtl/vec_step_pkg.sv | 23 ++
 rtl/vec_step_table.sv | 24 ++
 rtl/vec_step_ctrl.sv | 132 +++++++++++++
 tb/tb_vec_step_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/vec_step_pkg.sv
// Shared types and width helpers for the vector step sequencer.
package vec_step_pkg;

  localparam int DEF_WIDTH = 3;
  localparam int DEF_DEPTH = 8;

  typedef enum logic [1:0] {IDLE, PRE, APPLY, FIN} state_t;

  // Never returns 0, so a counter sized for a value of 0 or 1 still gets a bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int idx_width(input int depth);
    return clog2_min1(depth);
  endfunction

  // One extra bit so a length equal to depth is representable.
  function automatic int len_width(input int depth);
    return clog2_min1(depth) + 1;
  endfunction

endpackage

// File: rtl/vec_step_table.sv
// DEPTH x WIDTH vector store: synchronous write, combinational read.
module vec_step_table
  import vec_step_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [idx_width(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]            wdata,
  input  logic [idx_width(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]            rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/vec_step_ctrl.sv
// Stimulus sequencer: optional settle delay, then each table vector held for a
// fixed number of cycles, with a one-cycle DONE pulse at the end of a normal run.
module vec_step_ctrl
  import vec_step_pkg::*;
#(
  parameter int              WIDTH       = DEF_WIDTH,
  parameter int              DEPTH       = DEF_DEPTH,
  parameter int              HOLD_CYCLES = 4,
  parameter int              PRE_CYCLES  = 10,
  parameter logic [WIDTH-1:0] IDLE_VALUE = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_we,
  input  logic [idx_width(DEPTH)-1:0] cfg_addr,
  input  logic [WIDTH-1:0]            cfg_wdata,
  input  logic [len_width(DEPTH)-1:0] cfg_len,
  input  logic                        start,
  input  logic                        abort,
  output logic                        busy,
  output logic                        done,
  output logic                        vec_valid,
  output logic [idx_width(DEPTH)-1:0] vec_idx,
  output logic [WIDTH-1:0]            vec_out
);

  localparam int IDX_W  = idx_width(DEPTH);
  localparam int LEN_W  = len_width(DEPTH);
  localparam int PRE_W  = clog2_min1(PRE_CYCLES + 1);
  localparam int HOLD_W = clog2_min1(HOLD_CYCLES + 1);

  state_t            state, state_n;
  logic [PRE_W-1:0]  pre_cnt, pre_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [LEN_W-1:0]  len, len_n, len_req;
  logic              tbl_we;
  logic [WIDTH-1:0]  rd_data, vec_next;

  assign tbl_we  = cfg_we && (state == IDLE || state == FIN);
  assign len_req = (cfg_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : cfg_len;

  vec_step_table #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_table (
    .clk   (clk),
    .we    (tbl_we),
    .waddr (cfg_addr),
    .wdata (cfg_wdata),
    .raddr (idx_n),
    .rdata (rd_data)
  );

  // With no settle delay vector 0 is captured on the same edge as a table write.
  assign vec_next = (tbl_we && cfg_addr == idx_n) ? cfg_wdata : rd_data;

  always_comb begin
    state_n = state;
    pre_n   = pre_cnt;
    hold_n  = hold_cnt;
    idx_n   = idx;
    len_n   = len;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          len_n  = len_req;
          pre_n  = '0;
          hold_n = '0;
          idx_n  = '0;
          if (PRE_CYCLES > 0)   state_n = PRE;
          else if (len_req != 0) state_n = APPLY;
          else                   state_n = FIN;
        end
      end
      PRE: begin
        if (abort) begin
          state_n = IDLE;
        end else if (int'(pre_cnt) == PRE_CYCLES - 1) begin
          hold_n  = '0;
          idx_n   = '0;
          state_n = (len != 0) ? APPLY : FIN;
        end else begin
          pre_n = pre_cnt + PRE_W'(1);
        end
      end
      APPLY: begin
        if (abort) begin
          state_n = IDLE;
          idx_n   = '0;
        end else if (int'(hold_cnt) == HOLD_CYCLES - 1) begin
          hold_n = '0;
          if ((LEN_W'(idx) + LEN_W'(1)) == len) begin
            state_n = FIN;
            idx_n   = '0;
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end else begin
          hold_n = hold_cnt + HOLD_W'(1);
        end
      end
      FIN: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so they line up with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pre_cnt   <= '0;
      hold_cnt  <= '0;
      idx       <= '0;
      len       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      vec_valid <= 1'b0;
      vec_idx   <= '0;
      vec_out   <= IDLE_VALUE;
    end else begin
      state     <= state_n;
      pre_cnt   <= pre_n;
      hold_cnt  <= hold_n;
      idx       <= idx_n;
      len       <= len_n;
      busy      <= (state_n == PRE) || (state_n == APPLY);
      done      <= (state_n == FIN);
      vec_valid <= (state_n == APPLY);
      vec_idx   <= (state_n == APPLY) ? idx_n : '0;
      vec_out   <= (state_n == APPLY) ? vec_next : IDLE_VALUE;
    end
  end

endmodule

// File: tb/tb_vec_step_ctrl.sv
// Scoreboard bench for vec_step_ctrl: expected per-cycle outputs are queued
// when a run is started and compared one entry per clock.
module tb_vec_step_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = '0;
  logic [2:0] cfg_wdata = '0;
  logic [2:0] cfg_len = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       busy, done, vec_valid;
  logic [1:0] vec_idx;
  logic [2:0] vec_out;
  logic [7:0] obs;

  int n_checks = 0;
  int n_pass   = 0;

  logic [2:0] shadow [4];
  logic [7:0] exp_q [$];

  localparam logic [7:0] IDLE_EXP = 8'b0000_0000;
  localparam logic [7:0] FIN_EXP  = 8'b0100_0000;

  vec_step_ctrl #(
    .WIDTH(3), .DEPTH(4), .HOLD_CYCLES(2), .PRE_CYCLES(3), .IDLE_VALUE(3'b000)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_len(cfg_len), .start(start), .abort(abort),
    .busy(busy), .done(done), .vec_valid(vec_valid), .vec_idx(vec_idx),
    .vec_out(vec_out)
  );

  always #5 clk = ~clk;

  assign obs = {busy, done, vec_valid, vec_idx, vec_out};

  task automatic check_output(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got !== want)
      $display("[TB] FAIL %s: got {busy,done,valid,idx,out}=%b want %b", tag, got, want);
    else
      n_pass++;
  endtask

  function automatic logic [7:0] pk(input logic b, input logic d, input logic v,
                                    input logic [1:0] i, input logic [2:0] o);
    return {b, d, v, i, o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_check(input string tag);
    logic [7:0] want;
    tick();
    want = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_EXP;
    check_output(tag, obs, want);
  endtask

  task automatic push_pre();
    for (int i = 0; i < 3; i++) exp_q.push_back(pk(1'b1, 1'b0, 1'b0, 2'd0, 3'b000));
  endtask

  task automatic push_vec(input int j);
    exp_q.push_back(pk(1'b1, 1'b0, 1'b1, 2'(j), shadow[j]));
  endtask

  task automatic push_run(input int n);
    push_pre();
    for (int j = 0; j < n; j++) begin
      push_vec(j);
      push_vec(j);
    end
    exp_q.push_back(FIN_EXP);
    exp_q.push_back(IDLE_EXP);
  endtask

  task automatic write_table(input logic [1:0] addr, input logic [2:0] data);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    shadow[addr] = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [2:0] len, input string tag);
    int n;
    n = (len > 3'd4) ? 4 : int'(len);
    push_run(n);
    cfg_len = len;
    start   = 1'b1;
    step_check(tag);
    start  = 1'b0;
    cfg_we = 1'b0;
    while (exp_q.size() > 0) step_check(tag);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    $display("[TB] vec_step_ctrl bench start");

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_output("reset", obs, IDLE_EXP);

    write_table(2'd0, 3'b000);
    write_table(2'd1, 3'b101);
    write_table(2'd2, 3'b000);
    write_table(2'd3, 3'b110);
    apply_stimulus(3'd3, "normal_run");

    apply_stimulus(3'd0, "len_zero");
    apply_stimulus(3'd7, "len_clamp");

    // Abort at t+6 with an ignored second START during PRE.
    push_pre();
    push_vec(0);
    push_vec(0);
    push_vec(1);
    for (int i = 0; i < 3; i++) exp_q.push_back(IDLE_EXP);
    cfg_len = 3'd3;
    start   = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step_check("abort_run");
      start   = (i == 2);
      cfg_len = (i == 2) ? 3'd1 : 3'd3;
      abort   = (i == 6);
    end
    start = 1'b0;
    abort = 1'b0;

    start   = 1'b1;
    abort   = 1'b1;
    cfg_len = 3'd2;
    step_check("abort_start_idle");
    start = 1'b0;
    abort = 1'b0;
    step_check("abort_start_idle");
    step_check("abort_start_idle");

    // Table write attempted during APPLY must not land.
    push_run(2);
    n = exp_q.size();
    cfg_len = 3'd2;
    start   = 1'b1;
    for (int i = 1; i <= n; i++) begin
      step_check("we_busy");
      start     = 1'b0;
      cfg_we    = (i == 4);
      cfg_addr  = 2'd1;
      cfg_wdata = 3'b011;
    end
    cfg_we = 1'b0;
    apply_stimulus(3'd2, "readback");

    cfg_we    = 1'b1;
    cfg_addr  = 2'd0;
    cfg_wdata = 3'b111;
    shadow[0] = 3'b111;
    apply_stimulus(3'd1, "we_start");

    // Synchronous reset in the middle of a run.
    push_pre();
    push_vec(0);
    push_vec(0);
    exp_q.push_back(IDLE_EXP);
    exp_q.push_back(IDLE_EXP);
    cfg_len = 3'd3;
    start   = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step_check("mid_reset");
      start = 1'b0;
      rst   = (i == 5);
    end
    rst = 1'b0;
    apply_stimulus(3'd3, "after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
